// File: rtl/led_pattern_ctrl.sv
// led_pattern_ctrl: timebase prescaler plus mode state machine for the 4-LED bank.
// Patterns step on a prescaled tick; mode changes are accepted over a handshake
// and only take effect on a step boundary, so a pattern never changes mid-step.
//
// mode_valid / mode_ready handshake: a request transfers on a rising edge of
// sys_clk_50M where mode_valid and mode_ready are both high. After a transfer
// mode_ready stays low until the request has been applied on a step edge and
// one further cycle has passed. mode_valid seen while mode_ready is low is
// ignored (nothing is queued). The requester may drop mode_valid or change
// mode_sel at any time without a transfer occurring.
`timescale 1ns/1ps
module led_pattern_ctrl #(
   parameter logic [24:0] TICK_MAX     = 25'd24_999_999,
   parameter logic [2:0]  DEFAULT_MODE = 3'd1
) (
   input  logic       sys_clk_50M,
   input  logic       rst_n,
   input  logic [2:0] mode_sel,
   input  logic       mode_valid,
   output logic       mode_ready,
   input  logic [1:0] speed_sel,
   input  logic       pause,
   output logic       tick,
   output logic [2:0] cur_mode,
   output logic [3:0] led
);

   typedef enum logic [2:0] {
      MODE_OFF       = 3'd0,
      MODE_BLINK     = 3'd1,
      MODE_RUN_LEFT  = 3'd2,
      MODE_RUN_RIGHT = 3'd3,
      MODE_PINGPONG  = 3'd4
   } mode_e;

   localparam logic PP_LEFT  = 1'b0;
   localparam logic PP_RIGHT = 1'b1;

   // Codes 5-7 are legal requests but have no pattern of their own: they mean OFF.
   function automatic mode_e map_mode(input logic [2:0] code);
      if (code > 3'd4) return MODE_OFF;
      else             return mode_e'(code);
   endfunction

   // First visible LED state of each mode.
   function automatic logic [3:0] init_led(input mode_e m);
      case (m)
         MODE_OFF:       return 4'b0000;
         MODE_BLINK:     return 4'b1111;
         MODE_RUN_LEFT:  return 4'b0001;
         MODE_RUN_RIGHT: return 4'b1000;
         MODE_PINGPONG:  return 4'b0001;
         default:        return 4'b0000;
      endcase
   endfunction

   localparam mode_e      RST_MODE = map_mode(DEFAULT_MODE);
   localparam logic [3:0] RST_LED  = init_led(RST_MODE);

   logic [24:0] cnt_q, cnt_d;
   logic        tick_q, tick_d;
   logic        mode_ready_q, mode_ready_d;
   logic        pending_q, pending_d;
   mode_e       pend_mode_q, pend_mode_d;
   mode_e       cur_mode_q, cur_mode_d;
   logic [3:0]  led_q, led_d;
   logic        pp_dir_q, pp_dir_d;

   logic [24:0] limit;
   logic        step_en;
   logic        xfer;
   logic        apply;

   assign limit   = TICK_MAX >> speed_sel;
   assign step_en = (cnt_q == limit) && !pause;
   assign xfer    = mode_valid && mode_ready_q;
   assign apply   = step_en && pending_q;

   // Prescaler: count to the speed-dependent limit, clear on a step or when a
   // speed change leaves the count beyond the new limit; freeze while paused.
   always_comb begin
      cnt_d  = cnt_q;
      tick_d = step_en;
      if (!pause) begin
         if (step_en || (cnt_q > limit)) cnt_d = '0;
         else                            cnt_d = cnt_q + 25'd1;
      end
   end

   // Request capture: latch one mode request, release it when applied.
   always_comb begin
      pending_d    = pending_q;
      pend_mode_d  = pend_mode_q;
      if (apply) pending_d = 1'b0;
      if (xfer) begin
         pending_d   = 1'b1;
         pend_mode_d = map_mode(mode_sel);
      end
      // Ready comes back the cycle after pending has cleared.
      mode_ready_d = !xfer && !pending_q;
   end

   // Mode FSM next state: switch only when a pending request meets a step.
   always_comb begin
      cur_mode_d = cur_mode_q;
      if (apply) cur_mode_d = pend_mode_q;
   end

   // Mode FSM outputs: next LED pattern for the current mode on each step.
   always_comb begin
      led_d    = led_q;
      pp_dir_d = pp_dir_q;
      if (apply) begin
         led_d    = init_led(pend_mode_q);
         pp_dir_d = PP_LEFT;
      end else if (step_en) begin
         case (cur_mode_q)
            MODE_OFF:       led_d = 4'b0000;
            MODE_BLINK:     led_d = ~led_q;
            MODE_RUN_LEFT:  led_d = {led_q[2:0], led_q[3]};
            MODE_RUN_RIGHT: led_d = {led_q[0], led_q[3:1]};
            MODE_PINGPONG: begin
               // Bounce off either end before shifting.
               if (led_q == 4'b1000)      pp_dir_d = PP_RIGHT;
               else if (led_q == 4'b0001) pp_dir_d = PP_LEFT;
               led_d = (pp_dir_d == PP_LEFT) ? {led_q[2:0], 1'b0}
                                             : {1'b0, led_q[3:1]};
            end
            default:        led_d = 4'b0000;
         endcase
      end
   end

   // Mode FSM state register.
   always_ff @(posedge sys_clk_50M or negedge rst_n) begin
      if (!rst_n) cur_mode_q <= RST_MODE;
      else        cur_mode_q <= cur_mode_d;
   end

   // Datapath registers: prescaler, tick, handshake and LED pattern.
   always_ff @(posedge sys_clk_50M or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q        <= '0;
         tick_q       <= 1'b0;
         mode_ready_q <= 1'b1;
         pending_q    <= 1'b0;
         pend_mode_q  <= MODE_OFF;
         led_q        <= RST_LED;
         pp_dir_q     <= PP_LEFT;
      end else begin
         cnt_q        <= cnt_d;
         tick_q       <= tick_d;
         mode_ready_q <= mode_ready_d;
         pending_q    <= pending_d;
         pend_mode_q  <= pend_mode_d;
         led_q        <= led_d;
         pp_dir_q     <= pp_dir_d;
      end
   end

   assign mode_ready = mode_ready_q;
   assign tick       = tick_q;
   assign cur_mode   = cur_mode_q;
   assign led        = led_q;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// tb_led_pattern_ctrl: directed scenarios followed by random traffic, every
// cycle compared against a step-count based reference model.
`timescale 1ns/1ps
module tb_led_pattern_ctrl;

   localparam logic [24:0] TICK_MAX = 25'd9;

   logic       sys_clk_50M = 1'b0;
   logic       rst_n       = 1'b0;
   logic [2:0] mode_sel    = 3'd0;
   logic       mode_valid  = 1'b0;
   logic       mode_ready;
   logic [1:0] speed_sel   = 2'd0;
   logic       pause       = 1'b0;
   logic       tick;
   logic [2:0] cur_mode;
   logic [3:0] led;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: pattern is derived from steps taken since the mode began.
   int m_cnt, m_mode, m_pend_mode, m_k;
   bit m_tick, m_ready, m_pending, m_apply_prev;

   led_pattern_ctrl #(
      .TICK_MAX    (TICK_MAX),
      .DEFAULT_MODE(3'd1)
   ) dut (
      .sys_clk_50M(sys_clk_50M),
      .rst_n      (rst_n),
      .mode_sel   (mode_sel),
      .mode_valid (mode_valid),
      .mode_ready (mode_ready),
      .speed_sel  (speed_sel),
      .pause      (pause),
      .tick       (tick),
      .cur_mode   (cur_mode),
      .led        (led)
   );

   // Clock / reset block
   always #5 sys_clk_50M = ~sys_clk_50M;

   task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
   endtask

   function automatic logic [3:0] exp_led(input int mode, input int k);
      int pp_seq [6];
      pp_seq = '{1, 2, 4, 8, 4, 2};
      case (mode)
         1:       return (k % 2 == 0) ? 4'hF : 4'h0;
         2:       return 4'(1 << (k % 4));
         3:       return 4'(8 >> (k % 4));
         4:       return 4'(pp_seq[k % 6]);
         default: return 4'h0;
      endcase
   endfunction

   function automatic int cur_limit();
      return int'(TICK_MAX) >> speed_sel;
   endfunction

   task automatic model_reset();
      m_cnt = 0; m_tick = 0; m_ready = 1; m_pending = 0; m_apply_prev = 0;
      m_mode = 1; m_pend_mode = 0; m_k = 0;
   endtask

   // Advance the model by one clock using the inputs currently driven.
   task automatic model_step();
      int  limit;
      bit  step, xfer, apply;
      limit = cur_limit();
      step  = (m_cnt == limit) && !pause;
      xfer  = mode_valid && m_ready;
      apply = step && m_pending;
      if (!pause) begin
         if (step || m_cnt > limit) m_cnt = 0;
         else                       m_cnt = m_cnt + 1;
      end
      m_tick  = step;
      m_ready = xfer ? 1'b0 : (m_apply_prev ? 1'b1 : m_ready);
      m_apply_prev = apply;
      if (apply) begin
         m_mode = m_pend_mode; m_k = 0; m_pending = 0;
      end else if (step) begin
         m_k = m_k + 1;
      end
      if (xfer) begin
         m_pending   = 1;
         m_pend_mode = (mode_sel > 3'd4) ? 0 : int'(mode_sel);
      end
   endtask

   // Driver: one clock with the current inputs, then compare at the falling edge.
   task automatic drive_cycle();
      model_step();
      @(posedge sys_clk_50M);
      @(negedge sys_clk_50M);
      check_eq("tick",       8'(tick),       8'(m_tick));
      check_eq("led",        8'(led),        8'(exp_led(m_mode, m_k)));
      check_eq("cur_mode",   8'(cur_mode),   8'(m_mode));
      check_eq("mode_ready", 8'(mode_ready), 8'(m_ready));
   endtask

   task automatic run(input int n);
      repeat (n) drive_cycle();
   endtask

   // Asynchronous reset mid-cycle, checked before the next clock edge.
   task automatic apply_reset(input int hold_cycles);
      #2 rst_n = 1'b0;
      #1;
      check_eq("rst_tick",       8'(tick),       8'h00);
      check_eq("rst_led",        8'(led),        8'h0F);
      check_eq("rst_cur_mode",   8'(cur_mode),   8'h01);
      check_eq("rst_mode_ready", 8'(mode_ready), 8'h01);
      model_reset();
      repeat (hold_cycles) @(negedge sys_clk_50M);
      rst_n = 1'b1;
   endtask

   task automatic wait_cnt(input int target);
      int n = 0;
      while (m_cnt != target && n < 64) begin
         drive_cycle();
         n++;
      end
      if (m_cnt != target) begin
         n_checks++;
         $display("FAIL wait_cnt got=%0d exp=%0d", m_cnt, target);
      end
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!m_ready && n < 64) begin
         drive_cycle();
         n++;
      end
      if (!m_ready) begin
         n_checks++;
         $display("FAIL wait_ready timed out");
      end
   endtask

   // Stop one cycle before a step edge so a request can land on it.
   task automatic wait_step_edge();
      int n = 0;
      while (!(m_cnt == cur_limit() && !pause) && n < 64) begin
         drive_cycle();
         n++;
      end
      if (!(m_cnt == cur_limit() && !pause)) begin
         n_checks++;
         $display("FAIL wait_step_edge timed out");
      end
   endtask

   task automatic req(input logic [2:0] sel);
      mode_sel   = sel;
      mode_valid = 1'b1;
      drive_cycle();
      mode_valid = 1'b0;
   endtask

   initial begin
      @(negedge sys_clk_50M);
      apply_reset(2);

      // Default blink at speed 0.
      run(25);

      // Mid-period request for RUN_LEFT.
      wait_cnt(4);
      req(3'd2);
      run(60);

      // PINGPONG through several bounces.
      wait_ready();
      wait_cnt(3);
      req(3'd4);
      run(100);

      // Speed change with the count beyond the new limit, then other speeds.
      wait_cnt(7);
      speed_sel = 2'd3;
      run(10);
      speed_sel = 2'd2;
      run(12);
      speed_sel = 2'd0;
      run(12);

      // RUN_RIGHT, then pause with a mapped-to-OFF request accepted meanwhile.
      wait_ready();
      req(3'd3);
      run(25);
      pause = 1'b1;
      run(5);
      req(3'd6);
      run(20);
      pause = 1'b0;
      run(25);

      // Request landing on the step edge, then a request while not ready.
      wait_ready();
      wait_step_edge();
      req(3'd2);
      mode_sel   = 3'd4;
      mode_valid = 1'b1;
      run(3);
      mode_valid = 1'b0;
      run(30);

      // Requesting the current mode reloads its start pattern.
      wait_ready();
      req(3'd2);
      run(25);

      // Reset while a request is pending.
      wait_ready();
      req(3'd3);
      run(3);
      apply_reset(2);
      run(15);

      // Random traffic.
      for (int i = 0; i < 1000; i++) begin
         mode_valid = ($urandom_range(0, 5) == 0);
         mode_sel   = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 40) == 0) speed_sel = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 15) == 0) pause = ~pause;
         if ($urandom_range(0, 300) == 0) begin
            mode_valid = 1'b0;
            apply_reset(1);
         end else begin
            drive_cycle();
         end
      end
      mode_valid = 1'b0;
      pause      = 1'b0;
      run(10);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
